// File: rtl/bitlogic_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with a DEPTH-entry result queue and XOR accumulator.
// Optional define BITLOGIC_PARITY_EN adds out_par (odd parity over {in_a, in_b, in_op}).
module bitlogic_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_red
`ifdef BITLOGIC_PARITY_EN
  ,
  output logic             out_par
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
`ifdef BITLOGIC_PARITY_EN
  localparam int unsigned EntW = WIDTH + 2;
`else
  localparam int unsigned EntW = WIDTH + 1;
`endif

  logic [EntW-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d, remain;
  logic [WIDTH-1:0] acc_q, acc_d, result;
  logic [EntW-1:0]  new_ent, head_q, head_d;
  logic             push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count_q < CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    unique case (in_op)
      3'd0:    result = in_a & in_b;
      3'd1:    result = in_a | in_b;
      3'd2:    result = in_a ^ in_b;
      3'd3:    result = ~(in_a ^ in_b);
      3'd4:    result = ~(in_a & in_b);
      3'd5:    result = ~(in_a | in_b);
      3'd6:    result = in_a & ~in_b;
      default: result = acc_q ^ in_a;
    endcase
  end

  assign acc_d = (push && in_op == 3'd7) ? result : acc_q;

`ifdef BITLOGIC_PARITY_EN
  assign new_ent = {~(^{in_a, in_b, in_op}), ^result, result};
`else
  assign new_ent = {^result, result};
`endif

  always_comb begin
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
    remain   = count_q - CntW'(pop);
    head_d   = head_q;
    // The presented head is registered; it bypasses the array when the queue drains to
    // just the entry being written, and holds its last value once the queue is empty.
    if (count_d != '0) begin
      head_d = (push && remain == '0) ? new_ent : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= new_ent;
    end
  end

  assign out     = head_q[WIDTH-1:0];
  assign out_red = head_q[WIDTH];
`ifdef BITLOGIC_PARITY_EN
  assign out_par = head_q[WIDTH+1];
`endif

endmodule
